audio_frame_sequencer: RTL and testbench
========================================

// Module: audio_frame_sequencer
// PURPOSE
//  Sequences the free-running sample counter into overlapping analysis frames for the ML audio front end.
//  Counts accepted audio samples and emits one frame-start token per frame (first after frame_len_p, then every hop_len_p).
//  Each token goes to the feature extractor over a valid/ready handshake, and the block flags any overrun.
//  Sits between the I2S/PDM sample strobe and the feature-extraction datapath.
// PARAMETERS
//  width_p      8   width of the sample counter and the frame index; 2**width_p-1 >= frame_len_p
//  frame_len_p  16  samples per analysis frame; range 2..2**width_p-1
//  hop_len_p    8   samples between successive frame starts; range 1..frame_len_p
// PORTS
//  clk_i           in   1        single clock; all logic on posedge
//  reset_i         in   1        synchronous, active-high reset
//  en_i            in   1        sequencer enable
//  sample_valid_i  in   1        one-cycle strobe per incoming audio sample
//  frame_ready_i   in   1        downstream accepts the frame token
//  clear_ovr_i     in   1        clears sticky overrun_o
//  frame_valid_o   out  1        frame token pending
//  frame_idx_o     out  width_p  index of the pending frame; wraps mod 2**width_p
//  sample_cnt_o    out  width_p  samples counted toward the next frame boundary
//  busy_o          out  1        state != IDLE
//  overrun_o       out  1        sticky: a frame completed while the previous token was still pending
// BEHAVIOUR
//  Reset: state=IDLE and every output is 0. The internal next-index counter is 0.
//  States:
//   - IDLE -> FILL when en_i=1.
//   - FILL counts to frame_len_p; on the frame_len_p-th sample it completes a frame and moves to RUN.
//   - RUN counts to hop_len_p; on the hop_len_p-th sample it completes a frame and stays in RUN.
//   - In FILL or RUN, en_i=0 -> IDLE on the next edge, sample_cnt_o cleared to 0.
//  Counting:
//   - sample_cnt_o increments on each edge with sample_valid_i=1 in FILL/RUN.
//   - On a frame-completing sample it reloads to 0, not to the threshold.
//   - sample_valid_i is ignored in IDLE and on the edge en_i is first seen.
//  Frame completion, registered (1-cycle latency): frame_valid_o rises on the edge after the completing sample.
//   - If no token is pending, or the pending token handshakes on that edge:
//     frame_valid_o=1, frame_idx_o=next index, next index +1.
//   - If a token is pending and frame_ready_i=0: the new frame is dropped, overrun_o<=1.
//     The pending token and frame_idx_o are unchanged, but the next index still increments,
//     so the drop appears as an index gap.
//  Handshake:
//   - Transfer occurs on an edge with frame_valid_o&frame_ready_i.
//   - After a transfer with no new completion, frame_valid_o<=0 on that edge.
//   - frame_valid_o and frame_idx_o are stable while waiting. frame_ready_i may be high without valid (no effect).
//  en_i drop: a pending token stays valid until accepted. The next index is retained across IDLE.
//   - Re-enable restarts FILL, so a full frame_len_p samples are needed before the next frame.
//  overrun_o:
//   - Cleared by clear_ovr_i or reset_i.
//   - If set and clear happen on the same edge, set wins (overrun_o stays 1).
//  reset_i has priority over all inputs. Mid-frame reset discards the pending token and counts with no residual pulse.
// TESTING (defaults 16/8)
//  - Reset 3 cycles, en_i=1, 16 strobes every 4 cycles, ready=1 -> frame_valid_o 1 cycle after 16th strobe, idx=0, 1-cycle pulse.
//  - Continue 24 more strobes, ready=1 -> tokens after strobes 24,32,40, idx 1,2,3; sample_cnt_o never exceeds 7.
//  - Hold ready=0 across two hops -> first token held idx=1, overrun_o=1; release ready -> next token idx=3.
//  - Completion on same edge as handshake -> frame_valid_o stays 1, idx advances by 1, overrun_o=0.
//  - en_i=0 mid-RUN at sample_cnt_o=5 -> IDLE, cnt=0; re-enable -> next token only after 16 strobes.
//  - reset_i while token pending and overrun_o=1 -> all outputs 0 next edge; clear_ovr_i with simultaneous overrun -> stays 1.

Source files
------------

// File: rtl/audio_frame_sequencer.sv
`timescale 1ns/1ps
// audio_frame_sequencer: turns accepted audio sample strobes into overlapping
// analysis-frame start tokens (first after frame_len_p samples, then every
// hop_len_p samples) and hands each token downstream over valid/ready.
//
// Handshake: frame_valid_o/frame_idx_o are held stable while frame_valid_o=1
// and frame_ready_i=0; a token transfers on any posedge where both are high.
// frame_ready_i without frame_valid_o has no effect.
module audio_frame_sequencer #(
  parameter int width_p     = 8,
  parameter int frame_len_p = 16,
  parameter int hop_len_p   = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               sample_valid_i,
  input  logic               frame_ready_i,
  input  logic               clear_ovr_i,
  output logic               frame_valid_o,
  output logic [width_p-1:0] frame_idx_o,
  output logic [width_p-1:0] sample_cnt_o,
  output logic               busy_o,
  output logic               overrun_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Counter values on which the completing sample arrives.
  localparam logic [width_p-1:0] FillLast = width_p'(frame_len_p - 1);
  localparam logic [width_p-1:0] HopLast  = width_p'(hop_len_p - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [width_p-1:0] r_cnt;
  logic [width_p-1:0] w_cnt_nxt;
  logic [width_p-1:0] w_last;
  logic               w_done;
  logic               r_done;
  logic               r_valid;
  logic [width_p-1:0] r_idx;
  logic [width_p-1:0] r_next_idx;
  logic               r_ovr;
  logic               w_drop;

  // Next-state and sample counter: counts strobes toward the current boundary.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    w_last      = (r_state == FILL) ? FillLast : HopLast;
    case (r_state)
      IDLE: begin
        // Strobes are ignored here and on the edge that leaves IDLE.
        w_cnt_nxt = '0;
        if (en_i) w_state_nxt = FILL;
      end
      FILL, RUN: begin
        if (!en_i) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (sample_valid_i) begin
          if (r_cnt == w_last) begin
            w_cnt_nxt   = '0;
            w_done      = 1'b1;
            w_state_nxt = RUN;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and the one-cycle frame-complete flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done;
    end
  end

  // A completed frame is lost only if the previous token is still waiting
  // and is not leaving on this same edge.
  assign w_drop = r_done & r_valid & ~frame_ready_i;

  // Token register, frame index allocation and sticky overrun flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_valid    <= 1'b0;
      r_idx      <= '0;
      r_next_idx <= '0;
      r_ovr      <= 1'b0;
    end else begin
      if (r_done) begin
        // The index always advances so dropped frames show up as a gap.
        r_next_idx <= r_next_idx + 1'b1;
        if (!w_drop) begin
          r_valid <= 1'b1;
          r_idx   <= r_next_idx;
        end
      end else if (r_valid && frame_ready_i) begin
        r_valid <= 1'b0;
      end
      // A new overrun outranks a simultaneous clear.
      if (w_drop) begin
        r_ovr <= 1'b1;
      end else if (clear_ovr_i) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign frame_valid_o = r_valid;
  assign frame_idx_o   = r_idx;
  assign sample_cnt_o  = r_cnt;
  assign busy_o        = (r_state != IDLE);
  assign overrun_o     = r_ovr;

endmodule

// File: tb/tb_audio_frame_sequencer.sv
`timescale 1ns/1ps
// Bench for audio_frame_sequencer with default parameters (16/8, width 8).
module tb_audio_frame_sequencer;

  localparam int W = 8;

  logic         clk_i;
  logic         reset_i;
  logic         en_i;
  logic         sample_valid_i;
  logic         frame_ready_i;
  logic         clear_ovr_i;
  logic         frame_valid_o;
  logic [W-1:0] frame_idx_o;
  logic [W-1:0] sample_cnt_o;
  logic         busy_o;
  logic         overrun_o;

  audio_frame_sequencer #(
    .width_p    (W),
    .frame_len_p(16),
    .hop_len_p  (8)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .en_i          (en_i),
    .sample_valid_i(sample_valid_i),
    .frame_ready_i (frame_ready_i),
    .clear_ovr_i   (clear_ovr_i),
    .frame_valid_o (frame_valid_o),
    .frame_idx_o   (frame_idx_o),
    .sample_cnt_o  (sample_cnt_o),
    .busy_o        (busy_o),
    .overrun_o     (overrun_o)
  );

  // ---------------- clock ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  logic         track_max = 1'b0;
  logic [W-1:0] max_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Token monitor: a transfer happens on the next posedge when valid and
  // ready are both high (and reset is low); inputs are stable at negedge.
  always @(negedge clk_i) begin
    if (!reset_i && frame_valid_o && frame_ready_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL token_unexpected: got idx %0d expected none", frame_idx_o);
      end else begin
        chk("token_idx", 32'(frame_idx_o), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic en, input logic sv,
                      input logic rdy, input logic clr);
    reset_i        = rst;
    en_i           = en;
    sample_valid_i = sv;
    frame_ready_i  = rdy;
    clear_ovr_i    = clr;
    @(posedge clk_i);
    #1;
    if (track_max && sample_cnt_o > max_cnt) max_cnt = sample_cnt_o;
  endtask

  task automatic strobes(input int n, input int gap, input logic rdy);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, 1'b1, rdy, 1'b0);
      repeat (gap) step(1'b0, 1'b1, 1'b0, rdy, 1'b0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         en, sv, rdy, clr;
    logic         ev;
    logic [W-1:0] eidx, ecnt;
    logic         ebusy, eovr;
    logic         push;
    logic [W-1:0] pidx;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(input logic en, input logic sv, input logic rdy,
                               input logic clr, input logic ev, input int eidx,
                               input int ecnt, input logic ebusy, input logic eovr,
                               input logic push, input int pidx);
    vec_t v;
    v.en = en; v.sv = sv; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.eidx = W'(eidx); v.ecnt = W'(ecnt);
    v.ebusy = ebusy; v.eovr = eovr; v.push = push; v.pidx = W'(pidx);
    vecs.push_back(v);
  endfunction

  initial begin
    // Fill: first edge only enters FILL, then 16 strobes, token 0 one cycle later.
    addv(1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k < 16; k++) addv(1, 1, 1, 0, 0, 0, k, 1, 0, 0, 0);
    addv(1, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0);
    addv(1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    addv(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    // First hop: token 1.
    for (int h = 1; h < 8; h++) addv(1, 1, 1, 0, 0, 0, h, 1, 0, 0, 0);
    addv(1, 1, 1, 0, 0, 0, 0, 1, 0, 1, 1);
    // Hold token 1 through the next hop; release on the edge token 2 arrives.
    for (int h = 1; h < 8; h++) addv(1, 1, 0, 0, 1, 1, h, 1, 0, 0, 0);
    addv(1, 1, 0, 0, 1, 1, 0, 1, 0, 1, 2);
    addv(1, 0, 1, 0, 1, 2, 0, 1, 0, 0, 0);
    addv(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);

    // ---- reset ----
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_valid", 32'(frame_valid_o), 0);
    chk("rst_idx",   32'(frame_idx_o),   0);
    chk("rst_cnt",   32'(sample_cnt_o),  0);
    chk("rst_busy",  32'(busy_o),        0);
    chk("rst_ovr",   32'(overrun_o),     0);

    // ---- table phase ----
    foreach (vecs[i]) begin
      if (vecs[i].push) exp_q.push_back(vecs[i].pidx);
      step(1'b0, vecs[i].en, vecs[i].sv, vecs[i].rdy, vecs[i].clr);
      chk($sformatf("vec%0d_valid", i), 32'(frame_valid_o), 32'(vecs[i].ev));
      if (vecs[i].ev) chk($sformatf("vec%0d_idx", i), 32'(frame_idx_o), 32'(vecs[i].eidx));
      chk($sformatf("vec%0d_cnt", i),  32'(sample_cnt_o), 32'(vecs[i].ecnt));
      chk($sformatf("vec%0d_busy", i), 32'(busy_o),       32'(vecs[i].ebusy));
      chk($sformatf("vec%0d_ovr", i),  32'(overrun_o),    32'(vecs[i].eovr));
    end

    // ---- overrun: ready low across two hops ----
    track_max = 1'b1;
    exp_q.push_back(W'(3));
    strobes(8, 3, 1'b0);
    chk("ovr_hold_valid", 32'(frame_valid_o), 1);
    chk("ovr_hold_idx",   32'(frame_idx_o),   3);
    chk("ovr_hold_ovr",   32'(overrun_o),     0);
    strobes(8, 3, 1'b0);
    chk("ovr_drop_valid", 32'(frame_valid_o), 1);
    chk("ovr_drop_idx",   32'(frame_idx_o),   3);
    chk("ovr_drop_ovr",   32'(overrun_o),     1);

    // ---- clear alone, then clear colliding with a new overrun ----
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("clr_plain_ovr", 32'(overrun_o), 0);
    strobes(8, 0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("clr_vs_set_ovr", 32'(overrun_o),   1);
    chk("clr_vs_set_idx", 32'(frame_idx_o), 3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("clr_again_ovr", 32'(overrun_o), 0);

    // ---- release: token 3 leaves, next token shows the gap (idx 6) ----
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("release_valid", 32'(frame_valid_o), 0);
    exp_q.push_back(W'(6));
    strobes(7, 1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("gap_pre_valid", 32'(frame_valid_o), 0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("gap_valid", 32'(frame_valid_o), 1);
    chk("gap_idx",   32'(frame_idx_o),   6);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("gap_done_valid", 32'(frame_valid_o), 0);
    track_max = 1'b0;
    chk("run_max_cnt", 32'(max_cnt), 7);

    // ---- enable drop mid-RUN at count 5, then a full refill ----
    strobes(5, 1, 1'b1);
    chk("endrop_pre_cnt", 32'(sample_cnt_o), 5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("endrop_busy", 32'(busy_o),       0);
    chk("endrop_cnt",  32'(sample_cnt_o), 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("idle_ignore_cnt", 32'(sample_cnt_o), 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("reen_busy", 32'(busy_o),       1);
    chk("reen_cnt",  32'(sample_cnt_o), 0);
    strobes(15, 3, 1'b1);
    chk("refill_cnt",   32'(sample_cnt_o),  15);
    chk("refill_valid", 32'(frame_valid_o), 0);
    exp_q.push_back(W'(7));
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("refill_done_cnt", 32'(sample_cnt_o), 0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("refill_tok_valid", 32'(frame_valid_o), 1);
    chk("refill_tok_idx",   32'(frame_idx_o),   7);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("refill_tok_gone", 32'(frame_valid_o), 0);

    // ---- reset with a pending token and overrun set ----
    strobes(8, 1, 1'b0);
    strobes(8, 1, 1'b0);
    chk("pre_rst_valid", 32'(frame_valid_o), 1);
    chk("pre_rst_idx",   32'(frame_idx_o),   8);
    chk("pre_rst_ovr",   32'(overrun_o),     1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("mid_rst_valid", 32'(frame_valid_o), 0);
    chk("mid_rst_idx",   32'(frame_idx_o),   0);
    chk("mid_rst_cnt",   32'(sample_cnt_o),  0);
    chk("mid_rst_busy",  32'(busy_o),        0);
    chk("mid_rst_ovr",   32'(overrun_o),     0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_no_pulse", 32'(frame_valid_o), 0);

    // Index allocation restarts at 0 after reset.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(W'(0));
    strobes(16, 0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("post_rst_tok_valid", 32'(frame_valid_o), 1);
    chk("post_rst_tok_idx",   32'(frame_idx_o),   0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("post_rst_tok_gone", 32'(frame_valid_o), 0);

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
